// File: rtl/data_mem_responder.sv
// data_mem_responder: byte/half/word load-store responder for the execute
// stage memory port. Three-state FSM (IDLE -> ACCESS -> RESP) around a word
// array; loads return sign/zero-extended data two cycles after acceptance,
// stores complete one cycle after acceptance.
module data_mem_responder #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_data_wr_en,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_data_write_out,
  output logic        mem_ready,
  output logic        mem_rd_valid,
  output logic [31:0] mem_data_read_in,
  output logic        mem_wr_done,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hold_q, hold_d;
  logic        lerr_q, lerr_d;
  logic        rd_valid_q, rd_valid_d;
  logic        wr_done_q, wr_done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // Contents are deliberately left unreset.
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          req_err, misalign, oob, op_bad, store_fire, accept;
  logic [3:0]    be;
  logic [31:0]   wlane, ext;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign idx       = addr_q[AW+1:2];
  assign mem_ready = (state_q != ACCESS);
  assign accept    = mem_req && mem_ready;

  // Error classification of the latched request.
  always_comb begin
    misalign = ((op_q[1:0] == 2'b01) && addr_q[0]) ||
               ((op_q[1:0] == 2'b11) && (addr_q[1:0] != 2'b00));
    oob      = (addr_q >> (AW + 2)) != 32'd0;
    op_bad   = wr_q ? !(op_q inside {3'b000, 3'b001, 3'b011})
                    :  (op_q inside {3'b010, 3'b110, 3'b111});
    req_err  = misalign || oob || op_bad;
  end

  // Byte-lane enables and replicated store data for the selected lanes.
  always_comb begin
    case (op_q[1:0])
      2'b00:   begin be = 4'b0001 << addr_q[1:0];               wlane = {4{wdata_q[7:0]}};  end
      2'b01:   begin be = addr_q[1] ? 4'b1100 : 4'b0011;        wlane = {2{wdata_q[15:0]}}; end
      default: begin be = 4'b1111;                              wlane = wdata_q;            end
    endcase
  end

  // Lane extraction and sign/zero extension of the held word; op[2] = unsigned.
  always_comb begin
    byte_sel = hold_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? hold_q[31:16] : hold_q[15:0];
    case (op_q[1:0])
      2'b00:   ext = {{24{~op_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   ext = {{16{~op_q[2] & half_sel[15]}}, half_sel};
      default: ext = hold_q;
    endcase
  end

  assign store_fire = (state_q == ACCESS) && wr_q && !req_err;

  // Array write: only enabled lanes of an error-free store in ACCESS.
  always_ff @(posedge clock) begin
    if (store_fire)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
  end

  // Next-state, request latch and response pulses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    op_d       = op_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    lerr_d     = lerr_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    err_d      = 1'b0;
    if (accept) begin
      addr_d  = mem_addr;
      op_d    = mem_op;
      wr_d    = mem_data_wr_en;
      wdata_d = mem_data_write_out;
    end
    case (state_q)
      IDLE: if (mem_req) state_d = ACCESS;
      ACCESS: begin
        if (wr_q) begin
          wr_done_d = !req_err;
          err_d     = req_err;
          state_d   = IDLE;
        end else begin
          hold_d  = req_err ? 32'd0 : mem[idx];
          lerr_d  = req_err;
          state_d = RESP;
        end
      end
      RESP: begin
        rd_valid_d = 1'b1;
        err_d      = lerr_q;
        rdata_d    = lerr_q ? 32'd0 : ext;
        state_d    = mem_req ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; async reset also cancels in-flight pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      op_q       <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      hold_q     <= '0;
      lerr_q     <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      lerr_q     <= lerr_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      err_q      <= err_d;
    end
  end

  assign mem_rd_valid     = rd_valid_q;
  assign mem_wr_done      = wr_done_q;
  assign mem_err          = err_q;
  assign mem_data_read_in = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected
// responses, a negedge monitor pops and compares data, flags and latency.
module tb_data_mem_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_data_wr_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [2:0]  mem_op = '0;
  logic [31:0] mem_data_write_out = '0;
  logic        mem_ready, mem_rd_valid, mem_wr_done, mem_err;
  logic [31:0] mem_data_read_in;

  data_mem_responder #(.DEPTH_WORDS(256)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req),
    .mem_data_wr_en(mem_data_wr_en), .mem_addr(mem_addr), .mem_op(mem_op),
    .mem_data_write_out(mem_data_write_out), .mem_ready(mem_ready),
    .mem_rd_valid(mem_rd_valid), .mem_data_read_in(mem_data_read_in),
    .mem_wr_done(mem_wr_done), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          st;
    bit          err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   stamps[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request and hold it until accepted; optionally queue the expected response.
  task automatic issue(input bit wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input bit want, input bit err,
                       input logic [31:0] edata);
    int n;
    exp_t e;
    n = 0;
    mem_req = 1'b1; mem_data_wr_en = wr; mem_op = op;
    mem_addr = addr; mem_data_write_out = data;
    while (!mem_ready && n < 20) begin @(negedge clock); n++; end
    if (!mem_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready stayed low for addr %h", addr);
      mem_req = 1'b0;
      return;
    end
    @(posedge clock); #1;
    if (want) begin
      e.st = wr; e.err = err; e.data = edata; e.due = cyc + (wr ? 1 : 2);
      sbq.push_back(e);
    end
    mem_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(negedge clock); n++; end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses still pending", sbq.size());
      sbq.delete();
    end
    @(negedge clock);
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (mem_rd_valid || mem_wr_done || mem_err)) begin
      if (mem_rd_valid) stamps.push_back(cyc);
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: rv=%b wd=%b err=%b data=%h", mem_rd_valid,
                 mem_wr_done, mem_err, mem_data_read_in);
      end else begin
        e = sbq.pop_front();
        chk("resp_flags", 32'({mem_rd_valid, mem_wr_done, mem_err}),
            32'({!e.st, e.st && !e.err, e.err}));
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        if (!e.st) chk("load_data", mem_data_read_in, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_flags", 32'({mem_ready, mem_rd_valid, mem_wr_done, mem_err}), 32'h8);
    chk("reset_data", mem_data_read_in, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // word store / load and extensions
    issue(1, 3'b011, 32'h10, 32'h8000_00F0, 1, 0, 0);
    issue(0, 3'b011, 32'h10, 0, 1, 0, 32'h8000_00F0);
    issue(0, 3'b000, 32'h10, 0, 1, 0, 32'hFFFF_FFF0);
    issue(0, 3'b100, 32'h10, 0, 1, 0, 32'h0000_00F0);
    issue(0, 3'b001, 32'h12, 0, 1, 0, 32'hFFFF_8000);
    issue(0, 3'b101, 32'h12, 0, 1, 0, 32'h0000_8000);
    // partial-lane stores
    issue(1, 3'b011, 32'h10, 32'h1122_3344, 1, 0, 0);
    issue(1, 3'b000, 32'h11, 32'hFFFF_FFAB, 1, 0, 0);
    issue(0, 3'b011, 32'h10, 0, 1, 0, 32'h1122_AB44);
    issue(1, 3'b011, 32'h14, 32'h0, 1, 0, 0);
    issue(1, 3'b001, 32'h16, 32'hAAAA_5566, 1, 0, 0);
    issue(0, 3'b011, 32'h14, 0, 1, 0, 32'h5566_0000);
    // error cases
    issue(0, 3'b011, 32'h12, 0, 1, 1, 32'h0);
    issue(1, 3'b001, 32'h13, 32'h0000_7777, 1, 1, 0);
    issue(1, 3'b010, 32'h10, 32'h9999_9999, 1, 1, 0);
    issue(0, 3'b011, 32'h400, 0, 1, 1, 32'h0);
    issue(0, 3'b010, 32'h10, 0, 1, 1, 32'h0);
    issue(0, 3'b011, 32'h10, 0, 1, 0, 32'h1122_AB44);
    drain();

    // back-to-back loads with mem_req held
    stamps.delete();
    issue(0, 3'b011, 32'h10, 0, 1, 0, 32'h1122_AB44);
    issue(0, 3'b000, 32'h10, 0, 1, 0, 32'h0000_0044);
    issue(0, 3'b101, 32'h10, 0, 1, 0, 32'h0000_AB44);
    issue(0, 3'b000, 32'h11, 0, 1, 0, 32'hFFFF_FFAB);
    drain();
    chk("b2b_count", 32'(stamps.size()), 32'd4);
    if (stamps.size() == 4)
      for (int i = 1; i < 4; i++) chk("b2b_gap", 32'(stamps[i] - stamps[i-1]), 32'd2);

    // reset right after a store is accepted discards it
    issue(1, 3'b011, 32'h10, 32'hDEAD_BEEF, 0, 0, 0);
    reset = 1'b1;
    #2;
    chk("rst_store_ready", 32'(mem_ready), 32'h1);
    @(negedge clock);
    reset = 1'b0;
    issue(0, 3'b011, 32'h10, 0, 1, 0, 32'h1122_AB44);
    drain();

    // asynchronous reset while the load pulse is up
    issue(0, 3'b011, 32'h10, 0, 0, 0, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("pulse_before_reset", 32'({mem_rd_valid, mem_data_read_in == 32'h1122_AB44}), 32'h3);
    reset = 1'b1;
    #1;
    chk("async_reset_flags", 32'({mem_ready, mem_rd_valid, mem_wr_done, mem_err}), 32'h8);
    chk("async_reset_data", mem_data_read_in, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Data-memory responder on the far end of the execute stage's memory port.
- Accepts load/store requests: address from the ALU result, store data from `mem_data_write_out`, write strobe `mem_data_wr_en`.
- Performs byte/half/word accesses on an internal word array and returns sign- or zero-extended load data on `mem_data_read_in`.
- Sits between the execute stage and the writeback mux and replaces the bench-driven `mem_data_read_in`.

## Interface

- `DEPTH_WORDS`, default 256: number of 32-bit words in the array (power of two, ≥ 4).
- `AW`, default log2(DEPTH_WORDS): word-index width, derived and not overridden.

- `clock`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `mem_req`, input, 1: request valid. Sampled only when `mem_ready` = 1.
- `mem_data_wr_en`, input, 1: 1 = store, 0 = load. Qualified by `mem_req`.
- `mem_addr`, input, 32: byte address (execute `aluout`).
- `mem_op`, input, 3: access type.
  - Loads: 000 byte, 100 byte-unsigned, 001 half, 101 half-unsigned, 011 word.
  - Stores: 000 byte, 001 half, 011 word.
- `mem_data_write_out`, input, 32: store data, right-aligned.
- `mem_ready`, output, 1: a new request can be accepted this cycle.
- `mem_rd_valid`, output, 1: one-cycle pulse marking valid load data.
- `mem_data_read_in`, output, 32: extended load result. Holds its value between loads.
- `mem_wr_done`, output, 1: one-cycle pulse when a store completes.
- `mem_err`, output, 1: one-cycle pulse when a request completes with an error.

## Operation

- FSM states: IDLE, ACCESS, RESP.
  - IDLE: on `mem_req`, latch addr, op, wr_en and data, then go to ACCESS.
  - ACCESS: perform the store, or read the array word into a holding register. Store → IDLE; load → RESP.
  - RESP: drive extended data with `mem_rd_valid` = 1. A new `mem_req` → ACCESS; otherwise → IDLE.
- `mem_ready` = 1 in IDLE and RESP, 0 in ACCESS.
- Addressing:
  - Word index = addr[AW+1:2].
  - Little-endian: addr[1:0] = 0 selects bits 7:0; a half at addr[1] = 1 uses bits 31:16.
- Stores write only the selected byte lanes, taking the low 8/16/32 bits of the data. Other lanes are unchanged.
- Loads: signed ops replicate bit 7 or 15 into the upper bits; unsigned ops zero-fill.
- Error conditions, checked on the latched request in ACCESS:
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - addr ≥ 4·DEPTH_WORDS;
  - load op in {010, 110, 111};
  - store op not in {000, 001, 011}.
- Error handling:
  - Array is never modified.
  - Store: `mem_err` pulses instead of `mem_wr_done`.
  - Load: `mem_err` and `mem_rd_valid` pulse together and `mem_data_read_in` = 0.
- Array contents are not reset. `mem_req` is ignored while `mem_ready` = 0; the requester holds it.

## Timing

- Request accepted at edge N (IDLE or RESP, `mem_ready` = 1).
- Store: array updated at edge N+1. `mem_wr_done` (or `mem_err`) high for the cycle after N+1, and the FSM is back in IDLE.
- Load:
  - word captured at edge N+1;
  - `mem_rd_valid` = 1 and data valid for exactly the cycle after edge N+2;
  - load-to-data latency is 2 cycles.
- Back-to-back loads: a request accepted during RESP gives one load every 2 cycles.
- A load accepted in RESP directly after a store to the same word returns the new data.
- Reset values:
  - state IDLE;
  - `mem_ready` = 1;
  - `mem_rd_valid`, `mem_wr_done`, `mem_err` = 0;
  - `mem_data_read_in` = 0.
- Reset asserted before edge N+1 discards the pending store: the array is unchanged and no pulse is issued.
- Reset during RESP cancels the `mem_rd_valid` pulse immediately (asynchronous).
- First request is sampled at the first rising edge after reset deasserts.

## Test plan

- Reset: assert `reset` mid-cycle → all outputs reach reset values before the next edge; `mem_ready` = 1.
- Store word 0x8000_00F0 to addr 0x10, then LOADWORD 0x10 → `mem_wr_done` after 1 cycle; `mem_rd_valid` 2 cycles after acceptance with 0x8000_00F0.
- With 0x8000_00F0 at 0x10:
  - LOADBYTE 0x10 → 0xFFFF_FFF0; LOADBYTEU 0x10 → 0x0000_00F0;
  - LOADHALF 0x12 → 0xFFFF_8000; LOADHALFU 0x12 → 0x0000_8000.
- Store byte 0xAB to 0x11 over 0x1122_3344 → LOADWORD 0x10 returns 0x1122_AB44.
- Errors, each pulsing `mem_err`:
  - LOADWORD 0x12 → `mem_rd_valid` with data 0;
  - store half to 0x13 → no `mem_wr_done`, memory unchanged;
  - load from addr 0x400 with DEPTH_WORDS = 256 → data 0;
  - load op 010 → data 0.
- Back-to-back and reset: hold `mem_req` for 4 loads → `mem_rd_valid` every 2nd cycle; assert reset the cycle after accepting a store → later read returns the old data.
